fp32_norm_pipe: RTL

//  Two-stage pipelined FP32 post-add normalizer. Sits directly downstream of the
//  FP adder/subtractor magnitude datapath and upstream of rounding. It builds a
//  28-bit leading-zero count from seven 4-bit nibble zero counters (2-bit count

---
 rtl/fp32_norm_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fp32_norm_pipe.sv
// Two-stage FP32 post-add normalizer: S1 registers the operand and its leading-zero
// count, S2 shifts the mantissa so the hidden bit sits at bit 26 and fixes the exponent.
module fp32_norm_pipe #(
  parameter int MAN_W = 28,
  parameter int EXP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_man,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W-2:0] o_man,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int NIB = MAN_W / 4;
  localparam int LZW = $clog2(MAN_W + 1);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic             s1_v_q, s2_v_q;
  logic             s1_load, s2_load;
  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W-1:0] s1_man_q;
  logic [LZW-1:0]   s1_lzc_q;
  logic [LZW-1:0]   lzc_d;

  logic             s2_sign_q, s2_zero_q, s2_ovf_q, s2_unf_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [MAN_W-2:0] s2_man_q;
  logic             s2_zero_d, s2_ovf_d, s2_unf_d;
  logic [EXP_W-1:0] s2_exp_d;
  logic [MAN_W-2:0] s2_man_d;

  assign s2_load = !s2_v_q || i_ready;
  assign s1_load = !s1_v_q || s2_load;
  assign o_ready = s1_load;

  // {all_zero, count} for one nibble
  function automatic logic [2:0] nib_lzc(input logic [3:0] n);
    logic [2:0] r;
    casez (n)
      4'b1???: r = 3'b000;
      4'b01??: r = 3'b001;
      4'b001?: r = 3'b010;
      4'b0001: r = 3'b011;
      default: r = 3'b100;
    endcase
    return r;
  endfunction

  // Walk from the LSB nibble upwards so the most significant non-zero nibble wins.
  always_comb begin
    logic [2:0] nz;
    lzc_d = LZW'(MAN_W);
    for (int i = NIB - 1; i >= 0; i--) begin
      nz = nib_lzc(i_man[MAN_W-1-4*i -: 4]);
      if (!nz[2]) lzc_d = LZW'(4 * i) + LZW'(nz[1:0]);
    end
  end

  always_comb begin
    logic [EXP_W:0] exp_x;
    logic [EXP_W:0] sh_x;
    logic [EXP_W:0] diff;
    logic [LZW-1:0] sh;
    logic [LZW-1:0] ush;
    s2_zero_d = 1'b0;
    s2_ovf_d  = 1'b0;
    s2_unf_d  = 1'b0;
    s2_exp_d  = '0;
    s2_man_d  = '0;
    exp_x     = {1'b0, s1_exp_q};
    sh        = s1_lzc_q - LZW'(1);
    sh_x      = {{(EXP_W + 1 - LZW){1'b0}}, sh};
    diff      = exp_x - sh_x;
    ush       = (s1_exp_q == '0) ? '0 : LZW'(s1_exp_q - 1'b1);
    if (s1_man_q == '0) begin
      s2_zero_d = 1'b1;
    end else if (s1_man_q[MAN_W-1]) begin
      exp_x = exp_x + 1'b1;
      if (exp_x >= EXP_MAX) begin
        s2_ovf_d = 1'b1;
        s2_exp_d = '1;
      end else begin
        s2_exp_d = exp_x[EXP_W-1:0];
        s2_man_d = {s1_man_q[MAN_W-1:2], |s1_man_q[1:0]};
      end
    end else if (exp_x > sh_x) begin
      s2_exp_d = diff[EXP_W-1:0];
      s2_man_d = s1_man_q[MAN_W-2:0] << sh;
    end else begin
      // Exponent cannot absorb the full shift: denormal, shift only down to exp 1.
      s2_unf_d = 1'b1;
      s2_man_d = s1_man_q[MAN_W-2:0] << ush;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_man_q  <= '0;
      s1_lzc_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_man_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_ovf_q  <= 1'b0;
      s2_unf_q  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_v_q <= i_valid;
        if (i_valid) begin
          s1_sign_q <= i_sign;
          s1_exp_q  <= i_exp;
          s1_man_q  <= i_man;
          s1_lzc_q  <= lzc_d;
        end
      end
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_sign_q <= s1_sign_q;
          s2_exp_q  <= s2_exp_d;
          s2_man_q  <= s2_man_d;
          s2_zero_q <= s2_zero_d;
          s2_ovf_q  <= s2_ovf_d;
          s2_unf_q  <= s2_unf_d;
        end
      end
    end
  end

  assign o_valid = s2_v_q;
  assign o_sign  = s2_sign_q;
  assign o_exp   = s2_exp_q;
  assign o_man   = s2_man_q;
  assign o_zero  = s2_zero_q;
  assign o_ovf   = s2_ovf_q;
  assign o_unf   = s2_unf_q;

endmodule
